// File: rtl/requant_out_writer_pkg.sv
// Shared constants and state encoding for the requantization output writer.
// Defaults match the scale stage lane layout (6 int8 lanes per beat).
// No logic lives here.
package requant_out_writer_pkg;

    localparam int DN_DEF     = 6;
    localparam int OW_DEF     = 8;
    localparam int BW_DEF     = 32;
    localparam int WORD_BYTES = BW_DEF / 8;
    localparam int PACK_BYTES = DN_DEF + WORD_BYTES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, first-word-fall-through read data.
// Latency: write at edge t is visible on dout in cycle t+1.
// Backpressure: writes while full and reads while empty are ignored.
module sync_fifo #(
    parameter int W = 48,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] din,
    input  logic         rd,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(D);

    logic [W-1:0] mem [D];
    logic [PW:0]  wp;
    logic [PW:0]  rp;

    assign empty = (wp == rp);
    assign full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
    assign dout  = mem[rp[PW-1:0]];

    // Storage array, written only when there is room.
    always_ff @(posedge clk) begin
        if (wr && !full) begin
            mem[wp[PW-1:0]] <= din;
        end
    end

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr && !full) begin
                wp <= wp + 1'b1;
            end
            if (rd && !empty) begin
                rp <= rp + 1'b1;
            end
        end
    end

endmodule

// File: rtl/requant_out_writer.sv
// Buffers int8 lane beats from the scale stage and repacks them into BW-bit words for the output SRAM.
// Latency: s_valid in cycle t -> wr_en high in cycle t+2 with an empty buffer and wr_ready high.
// Backpressure: wr_ready stalls the word port; the input has no ready, so FIFO overflow drops beats (err_ovf).
module requant_out_writer
    import requant_out_writer_pkg::*;
#(
    parameter int DN = DN_DEF,
    parameter int OW = OW_DEF,
    parameter int BW = BW_DEF,
    parameter int AW = 16,
    parameter int FD = 8,
    parameter int CW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    cfg_base,
    input  logic [CW-1:0]    cfg_num,
    input  logic [DN*OW-1:0] s_data,
    input  logic             s_valid,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [BW-1:0]    wr_data,
    input  logic             wr_ready,
    output logic             busy,
    output logic             done,
    output logic             err_ovf,
    output logic             err_stray
);
    localparam int WB   = BW / 8;
    localparam int PB   = DN + WB;
    localparam int PBW  = PB * 8;
    localparam int CNTW = $clog2(PB + 1);

    state_t          state;
    logic [CW-1:0]   num_r;
    logic [CW-1:0]   beats_rx;
    logic [PBW-1:0]  pbuf;
    logic [CNTW-1:0] cnt;

    logic             in_take;
    logic             fifo_wr;
    logic             fifo_full;
    logic             fifo_empty;
    logic [DN*OW-1:0] fifo_dout;
    logic             pop;
    logic             accept;
    logic [PBW-1:0]   buf_a;
    logic [PBW-1:0]   buf_n;
    logic [CNTW-1:0]  cnt_a;
    logic [CNTW-1:0]  cnt_n;
    logic             tile_end;

    sync_fifo #(
        .W (DN * OW),
        .D (FD)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (fifo_wr),
        .din   (s_data),
        .rd    (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next pack-buffer contents: retire the accepted word first, then append the popped beat above it.
    always_comb begin
        in_take  = s_valid && (state == ST_RUN) && (beats_rx < num_r);
        fifo_wr  = in_take && !fifo_full;
        accept   = wr_en && wr_ready;
        pop      = (state == ST_RUN) && !fifo_empty && (cnt <= CNTW'(PB - DN));
        buf_a    = accept ? (pbuf >> BW) : pbuf;
        cnt_a    = accept ? (cnt - CNTW'(WB)) : cnt;
        buf_n    = pop ? (buf_a | (PBW'(fifo_dout) << {cnt_a, 3'b000})) : buf_a;
        cnt_n    = pop ? (cnt_a + CNTW'(DN)) : cnt_a;
        tile_end = (beats_rx == num_r) && fifo_empty && (cnt < CNTW'(WB));
    end

    // Control FSM with registered write port, status and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            num_r     <= '0;
            beats_rx  <= '0;
            pbuf      <= '0;
            cnt       <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_ovf   <= 1'b0;
            err_stray <= 1'b0;
        end else begin
            done <= 1'b0;
            if (in_take && fifo_full) begin
                err_ovf <= 1'b1;
            end
            if (s_valid && !in_take) begin
                err_stray <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        wr_addr  <= cfg_base;
                        num_r    <= cfg_num;
                        beats_rx <= '0;
                        busy     <= 1'b1;
                        if (cfg_num == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // Dropped beats still count so the tile always terminates.
                    if (in_take) begin
                        beats_rx <= beats_rx + CW'(1);
                    end
                    pbuf    <= buf_n;
                    cnt     <= cnt_n;
                    wr_en   <= (cnt_n >= CNTW'(WB));
                    wr_data <= buf_n[BW-1:0];
                    if (accept) begin
                        wr_addr <= wr_addr + AW'(1);
                    end
                    if (tile_end && !wr_en) begin
                        if (cnt != '0) begin
                            // Residual bytes go out as one word; upper bytes are already zero.
                            state   <= ST_FLUSH;
                            wr_en   <= 1'b1;
                            wr_data <= pbuf[BW-1:0];
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (accept) begin
                        wr_en   <= 1'b0;
                        wr_addr <= wr_addr + AW'(1);
                        pbuf    <= '0;
                        cnt     <= '0;
                        state   <= ST_DONE;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
